vit_tile_sequencer: RTL and testbench

VIT_TILE_SEQUENCER -- requirements
Module: vit_tile_sequencer

---
 rtl/vit_tile_sequencer_if.sv | 30 +++
 rtl/vit_tile_sequencer.sv | 160 ++++++++++++++++
 tb/tb_vit_tile_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vit_tile_sequencer_if.sv
// Handshake bundle between the tile sequencer, its host and the three engines
// (dual BRAM reader, matmul, writeback).
interface vit_tile_sequencer_if #(
  parameter int TILE_W = 8,
  parameter int TO_W   = 16
) ();
  logic              cmd_start;
  logic [TILE_W-1:0] cfg_num_tiles;
  logic [TO_W-1:0]   cfg_timeout;
  logic              cmd_busy;
  logic              cmd_done;
  logic              cmd_error;
  logic [TILE_W-1:0] tile_idx;
  logic              ld_start;
  logic              ld_done;
  logic              mm_start;
  logic              mm_done;
  logic              wb_start;
  logic              wb_done;

  modport master (
    output cmd_start, cfg_num_tiles, cfg_timeout, ld_done, mm_done, wb_done,
    input  cmd_busy, cmd_done, cmd_error, tile_idx, ld_start, mm_start, wb_start
  );

  modport slave (
    input  cmd_start, cfg_num_tiles, cfg_timeout, ld_done, mm_done, wb_done,
    output cmd_busy, cmd_done, cmd_error, tile_idx, ld_start, mm_start, wb_start
  );
endinterface

// File: rtl/vit_tile_sequencer.sv
// Per-tile load -> matmul -> writeback sequencer with a per-wait-phase watchdog.
// All start pulses and cmd_done/cmd_error come straight from flops.
module vit_tile_sequencer #(
  parameter int TILE_W = 8,
  parameter int TO_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  vit_tile_sequencer_if.slave   bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LD_REQ  = 4'd1,
    S_LD_WAIT = 4'd2,
    S_MM_REQ  = 4'd3,
    S_MM_WAIT = 4'd4,
    S_WB_REQ  = 4'd5,
    S_WB_WAIT = 4'd6,
    S_NEXT    = 4'd7,
    S_FIN     = 4'd8,
    S_ERR     = 4'd9
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [TILE_W-1:0] r_num_tiles;
  logic [TILE_W-1:0] r_tile;
  logic [TO_W-1:0]   r_timeout;
  logic [TO_W-1:0]   r_wd;
  logic [TO_W-1:0]   w_wd_inc;
  logic              w_expire;
  logic              w_in_wait;
  logic              w_accept;
  logic              w_last;
  logic              r_ld_start;
  logic              r_mm_start;
  logic              r_wb_start;
  logic              r_cmd_done;
  logic              r_cmd_error;
  logic              w_ld_start_d;
  logic              w_mm_start_d;
  logic              w_wb_start_d;
  logic              w_cmd_done_d;
  logic              w_cmd_error_d;

  assign w_in_wait = (r_state == S_LD_WAIT) || (r_state == S_MM_WAIT) ||
                     (r_state == S_WB_WAIT);
  assign w_accept  = (r_state == S_IDLE) && bus.cmd_start;
  assign w_wd_inc  = r_wd + {{(TO_W-1){1'b0}}, 1'b1};
  // Expires on the cfg_timeout-th consecutive wait cycle; a zero timeout never expires.
  assign w_expire  = (r_timeout != {TO_W{1'b0}}) && (w_wd_inc == r_timeout);
  assign w_last    = (r_tile == (r_num_tiles - {{(TILE_W-1){1'b0}}, 1'b1}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_start) begin
          w_next = (bus.cfg_num_tiles != {TILE_W{1'b0}}) ? S_LD_REQ : S_FIN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LD_REQ:  w_next = S_LD_WAIT;
      // Done is checked before expiry so a coinciding done still advances.
      S_LD_WAIT: begin
        if (bus.ld_done)   w_next = S_MM_REQ;
        else if (w_expire) w_next = S_ERR;
        else               w_next = S_LD_WAIT;
      end
      S_MM_REQ:  w_next = S_MM_WAIT;
      S_MM_WAIT: begin
        if (bus.mm_done)   w_next = S_WB_REQ;
        else if (w_expire) w_next = S_ERR;
        else               w_next = S_MM_WAIT;
      end
      S_WB_REQ:  w_next = S_WB_WAIT;
      S_WB_WAIT: begin
        if (bus.wb_done)   w_next = S_NEXT;
        else if (w_expire) w_next = S_ERR;
        else               w_next = S_WB_WAIT;
      end
      S_NEXT:    w_next = w_last ? S_FIN : S_LD_REQ;
      S_FIN:     w_next = S_IDLE;
      S_ERR:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Start pulses are decoded from the next state so they line up with the REQ cycle.
  always_comb begin
    w_ld_start_d  = (w_next == S_LD_REQ);
    w_mm_start_d  = (w_next == S_MM_REQ);
    w_wb_start_d  = (w_next == S_WB_REQ);
    w_cmd_done_d  = (r_state == S_FIN);
    w_cmd_error_d = r_cmd_error;
    if (w_next == S_ERR) begin
      w_cmd_error_d = 1'b1;
    end else if (w_accept) begin
      w_cmd_error_d = 1'b0;
    end else begin
      w_cmd_error_d = r_cmd_error;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_start  <= 1'b0;
      r_mm_start  <= 1'b0;
      r_wb_start  <= 1'b0;
      r_cmd_done  <= 1'b0;
      r_cmd_error <= 1'b0;
    end else begin
      r_ld_start  <= w_ld_start_d;
      r_mm_start  <= w_mm_start_d;
      r_wb_start  <= w_wb_start_d;
      r_cmd_done  <= w_cmd_done_d;
      r_cmd_error <= w_cmd_error_d;
    end
  end

  // Job configuration, tile counter and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num_tiles <= {TILE_W{1'b0}};
      r_timeout   <= {TO_W{1'b0}};
      r_tile      <= {TILE_W{1'b0}};
      r_wd        <= {TO_W{1'b0}};
    end else begin
      if (w_accept) begin
        r_num_tiles <= bus.cfg_num_tiles;
        r_timeout   <= bus.cfg_timeout;
        r_tile      <= {TILE_W{1'b0}};
      end else if ((r_state == S_NEXT) && !w_last) begin
        r_tile <= r_tile + {{(TILE_W-1){1'b0}}, 1'b1};
      end else begin
        r_tile <= r_tile;
      end
      r_wd <= w_in_wait ? w_wd_inc : {TO_W{1'b0}};
    end
  end

  assign bus.cmd_busy  = (r_state != S_IDLE);
  assign bus.cmd_done  = r_cmd_done;
  assign bus.cmd_error = r_cmd_error;
  assign bus.tile_idx  = r_tile;
  assign bus.ld_start  = r_ld_start;
  assign bus.mm_start  = r_mm_start;
  assign bus.wb_start  = r_wb_start;

endmodule

// File: tb/tb_vit_tile_sequencer.sv
// Directed bench for vit_tile_sequencer: auto-responding engine models plus
// cycle-scripted done pulses, with hand-computed latencies and pulse counts.
module tb_vit_tile_sequencer;

  logic clk;
  logic rst;
  vit_tile_sequencer_if #(.TILE_W(8), .TO_W(16)) bus ();

  vit_tile_sequencer #(.TILE_W(8), .TO_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Engine model controls
  bit   auto_en = 1'b1;
  int   d_ld = 1, d_mm = 1, d_wb = 1;
  int   mm_hold_tile = -1;
  int   ld_cnt = 0, mm_cnt = 0, wb_cnt = 0;
  logic resp_ld = 1'b0, resp_mm = 1'b0, resp_wb = 1'b0;
  logic man_ld = 1'b0, man_mm = 1'b0, man_wb = 1'b0;

  assign bus.ld_done = resp_ld | man_ld;
  assign bus.mm_done = resp_mm | man_mm;
  assign bus.wb_done = resp_wb | man_wb;

  // Engines: done pulse d_* cycles after the start pulse; not reset by rst.
  always @(negedge clk) begin
    if (ld_cnt > 0) begin ld_cnt <= ld_cnt - 1; resp_ld <= (ld_cnt == 1); end
    else resp_ld <= 1'b0;
    if (mm_cnt > 0) begin mm_cnt <= mm_cnt - 1; resp_mm <= (mm_cnt == 1); end
    else resp_mm <= 1'b0;
    if (wb_cnt > 0) begin wb_cnt <= wb_cnt - 1; resp_wb <= (wb_cnt == 1); end
    else resp_wb <= 1'b0;
    if (auto_en && bus.ld_start === 1'b1) ld_cnt <= d_ld;
    if (auto_en && bus.mm_start === 1'b1 && int'(bus.tile_idx) != mm_hold_tile) mm_cnt <= d_mm;
    if (auto_en && bus.wb_start === 1'b1) wb_cnt <= d_wb;
  end

  // Pulse counters and ld->mm->wb ordering monitor
  int         n_ld = 0, n_mm = 0, n_wb = 0, n_done = 0, ord_err = 0, last_ph = 0;
  logic [7:0] tiles[$];

  always @(negedge clk) begin
    if (bus.ld_start === 1'b1) begin n_ld <= n_ld + 1; tiles.push_back(bus.tile_idx); end
    if (bus.mm_start === 1'b1) n_mm <= n_mm + 1;
    if (bus.wb_start === 1'b1) n_wb <= n_wb + 1;
    if (bus.cmd_done === 1'b1) n_done <= n_done + 1;
    if (rst) last_ph <= 0;
    else if (bus.ld_start === 1'b1) last_ph <= 1;
    else if (bus.mm_start === 1'b1) begin
      if (last_ph != 1) ord_err <= ord_err + 1;
      last_ph <= 2;
    end else if (bus.wb_start === 1'b1) begin
      if (last_ph != 2) ord_err <= ord_err + 1;
      last_ph <= 3;
    end
  end

  // Launch a job at the current negedge (cycle 0) and watch until it ends.
  task automatic run_job(input int n, input int to, input bit hold, input int budget,
                         output int done_at, output int err_at, output int mm1_at,
                         output int busy_cyc);
    bus.cmd_start     = 1'b1;
    bus.cfg_num_tiles = n[7:0];
    bus.cfg_timeout   = to[15:0];
    done_at = -1; err_at = -1; mm1_at = -1; busy_cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (hold) begin bus.cfg_num_tiles = 8'd5; bus.cfg_timeout = 16'd2; end
        else bus.cmd_start = 1'b0;
      end
      if (bus.cmd_busy === 1'b1) busy_cyc++;
      if (bus.cmd_done === 1'b1 && done_at < 0) done_at = i;
      if (bus.cmd_error === 1'b1 && err_at < 0) err_at = i;
      if (bus.mm_start === 1'b1 && bus.tile_idx == 8'd1) mm1_at = i;
      if ((done_at > 0 || err_at > 0) && bus.cmd_busy === 1'b0) break;
    end
    bus.cmd_start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Job with engine dones driven on fixed cycles (relative to cmd_start cycle 0).
  task automatic manual_job(input int n, input int to, input int ld_c, input int ld2_c,
                            input int mm_c, input int wb_c, output int done_at,
                            output int err_at, output int mm_seen);
    auto_en = 1'b0;
    bus.cmd_start     = 1'b1;
    bus.cfg_num_tiles = n[7:0];
    bus.cfg_timeout   = to[15:0];
    done_at = -1; err_at = -1; mm_seen = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.cmd_start = 1'b0;
      if (bus.cmd_done === 1'b1 && done_at < 0) done_at = i;
      if (bus.cmd_error === 1'b1 && err_at < 0) err_at = i;
      if (bus.mm_start === 1'b1) mm_seen++;
      man_ld = (i == ld_c) || (i == ld2_c);
      man_mm = (i == mm_c);
      man_wb = (i == wb_c);
    end
    man_ld = 1'b0; man_mm = 1'b0; man_wb = 1'b0;
    auto_en = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.cmd_start = 1'b0; bus.cfg_num_tiles = 8'd0; bus.cfg_timeout = 16'd0;
    #2 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.cmd_busy, bus.cmd_done, bus.cmd_error, bus.ld_start, bus.mm_start,
         bus.wb_start, bus.tile_idx} !== 14'd0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=0", {bus.cmd_busy, bus.cmd_done, bus.cmd_error,
               bus.ld_start, bus.mm_start, bus.wb_start, bus.tile_idx});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.cmd_busy, bus.cmd_done, bus.cmd_error} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=000", {bus.cmd_busy, bus.cmd_done, bus.cmd_error});
    end
  endtask

  task automatic test_zero_tiles;
    int da, ea, ma, bc, b_st, b_dn;
    b_st = n_ld + n_mm + n_wb; b_dn = n_done;
    run_job(0, 0, 1'b0, 20, da, ea, ma, bc);
    checks++;
    if (da !== 2) begin failures++; $display("FAIL n0_done_latency got=%0d exp=2", da); end
    checks++;
    if (bc !== 1) begin failures++; $display("FAIL n0_busy_cycles got=%0d exp=1", bc); end
    checks++;
    if ((n_ld + n_mm + n_wb) - b_st !== 0) begin
      failures++; $display("FAIL n0_start_pulses got=%0d exp=0", (n_ld + n_mm + n_wb) - b_st);
    end
    checks++;
    if (n_done - b_dn !== 1) begin failures++; $display("FAIL n0_done_count got=%0d exp=1", n_done - b_dn); end
  endtask

  task automatic test_three_tiles;
    int da, ea, ma, bc, b_ld, b_mm, b_wb, b_dn, b_or, b_q;
    logic [23:0] tv;
    d_ld = 5; d_mm = 5; d_wb = 5;
    b_ld = n_ld; b_mm = n_mm; b_wb = n_wb; b_dn = n_done; b_or = ord_err; b_q = tiles.size();
    run_job(3, 100, 1'b0, 200, da, ea, ma, bc);
    checks++;
    if (da !== 59) begin failures++; $display("FAIL n3_latency got=%0d exp=59", da); end
    checks++;
    if ({n_ld - b_ld, n_mm - b_mm, n_wb - b_wb} !== {32'd3, 32'd3, 32'd3}) begin
      failures++;
      $display("FAIL n3_pulse_counts got=%0d/%0d/%0d exp=3/3/3", n_ld - b_ld, n_mm - b_mm, n_wb - b_wb);
    end
    checks++;
    if (tiles.size() >= b_q + 3) tv = {tiles[b_q], tiles[b_q+1], tiles[b_q+2]};
    else tv = 24'hffffff;
    if (tv !== 24'h000102) begin failures++; $display("FAIL n3_tile_seq got=%h exp=000102", tv); end
    checks++;
    if (n_done - b_dn !== 1 || ea !== -1) begin
      failures++; $display("FAIL n3_done_once got=%0d err_at=%0d exp=1 err_at=-1", n_done - b_dn, ea);
    end
    checks++;
    if (ord_err - b_or !== 0) begin failures++; $display("FAIL n3_order got=%0d exp=0", ord_err - b_or); end
    d_ld = 1; d_mm = 1; d_wb = 1;
  endtask

  task automatic test_back_to_back;
    int da, ea, ma, bc;
    run_job(2, 0, 1'b0, 100, da, ea, ma, bc);
    checks++;
    if (da !== 16) begin failures++; $display("FAIL b2b_n2_latency got=%0d exp=16", da); end
    run_job(1, 0, 1'b0, 100, da, ea, ma, bc);
    checks++;
    if (da !== 9) begin failures++; $display("FAIL b2b_n1_latency got=%0d exp=9", da); end
  endtask

  task automatic test_max_tiles;
    int da, ea, ma, bc, b_ld;
    logic [7:0] lt;
    b_ld = n_ld;
    run_job(255, 3, 1'b0, 2000, da, ea, ma, bc);
    checks++;
    if (da !== 1787) begin failures++; $display("FAIL n255_latency got=%0d exp=1787", da); end
    checks++;
    lt = (tiles.size() > 0) ? tiles[tiles.size()-1] : 8'h00;
    if (n_ld - b_ld !== 255 || lt !== 8'd254) begin
      failures++; $display("FAIL n255_tiles got=%0d last=%0d exp=255 last=254", n_ld - b_ld, lt);
    end
  endtask

  task automatic test_timeout;
    int da, ea, ma, bc, b_ld, b_mm, b_wb;
    mm_hold_tile = 1;
    b_ld = n_ld; b_mm = n_mm; b_wb = n_wb;
    run_job(3, 10, 1'b0, 200, da, ea, ma, bc);
    checks++;
    if (ma !== 10 || ea !== 21) begin
      failures++; $display("FAIL timeout_cycle got=mm%0d/err%0d exp=mm10/err21", ma, ea);
    end
    checks++;
    if (da !== -1) begin failures++; $display("FAIL timeout_no_done got=%0d exp=-1", da); end
    checks++;
    if ({n_ld - b_ld, n_mm - b_mm, n_wb - b_wb} !== {32'd2, 32'd2, 32'd1}) begin
      failures++;
      $display("FAIL timeout_pulses got=%0d/%0d/%0d exp=2/2/1", n_ld - b_ld, n_mm - b_mm, n_wb - b_wb);
    end
    checks++;
    if ({bus.cmd_error, bus.cmd_busy} !== 2'b10) begin
      failures++; $display("FAIL error_sticky got=%b exp=10", {bus.cmd_error, bus.cmd_busy});
    end
    mm_hold_tile = -1;
    run_job(1, 10, 1'b0, 100, da, ea, ma, bc);
    checks++;
    if (da !== 9 || ea !== -1 || bus.cmd_error !== 1'b0) begin
      failures++; $display("FAIL error_cleared got=done%0d/err%0d exp=done9/err-1", da, ea);
    end
  endtask

  task automatic test_watchdog_off;
    int da, ea, ma, bc;
    d_ld = 40; d_mm = 40; d_wb = 40;
    run_job(1, 0, 1'b0, 300, da, ea, ma, bc);
    checks++;
    if (da !== 126 || ea !== -1) begin
      failures++; $display("FAIL wd_disabled got=done%0d/err%0d exp=done126/err-1", da, ea);
    end
    d_ld = 1; d_mm = 1; d_wb = 1;
  endtask

  task automatic test_same_cycle_done;
    int da, ea, ms;
    manual_job(1, 3, 1, -1, -1, -1, da, ea, ms);
    checks++;
    if (ea !== 5 || ms !== 0 || da !== -1) begin
      failures++; $display("FAIL req_cycle_done got=err%0d/mm%0d/done%0d exp=err5/mm0/done-1", ea, ms, da);
    end
  endtask

  task automatic test_done_wins;
    int da, ea, ms;
    manual_job(1, 4, 2, 5, 7, 9, da, ea, ms);
    checks++;
    if (da !== 12 || ea !== -1 || ms !== 1) begin
      failures++; $display("FAIL done_wins got=done%0d/err%0d/mm%0d exp=done12/err-1/mm1", da, ea, ms);
    end
  endtask

  task automatic test_abort_reset;
    int found, b_ld, b_dn;
    found = 0;
    d_ld = 5; d_mm = 5; d_wb = 5;
    bus.cmd_start = 1'b1; bus.cfg_num_tiles = 8'd3; bus.cfg_timeout = 16'd0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      bus.cmd_start = 1'b0;
      if (bus.ld_start === 1'b1 && bus.tile_idx == 8'd2) begin found = 1; break; end
    end
    checks++;
    if (found !== 1) begin failures++; $display("FAIL abort_reach_tile2 got=%0d exp=1", found); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.cmd_busy, bus.cmd_done, bus.cmd_error, bus.ld_start, bus.mm_start,
         bus.wb_start, bus.tile_idx} !== 14'd0) begin
      failures++; $display("FAIL abort_outputs got=%b exp=0", {bus.cmd_busy, bus.cmd_done,
               bus.cmd_error, bus.ld_start, bus.mm_start, bus.wb_start, bus.tile_idx});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b_ld = n_ld; b_dn = n_done;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.cmd_busy !== 1'b0 || bus.tile_idx !== 8'd0 || n_ld - b_ld !== 0 || n_done - b_dn !== 0) begin
      failures++; $display("FAIL abort_stays_idle got=busy%b/tile%0d/ld%0d exp=busy0/tile0/ld0",
                           bus.cmd_busy, bus.tile_idx, n_ld - b_ld);
    end
    d_ld = 1; d_mm = 1; d_wb = 1;
  endtask

  task automatic test_busy_ignore;
    int da, ea, ma, bc, b_ld, b_dn;
    b_ld = n_ld; b_dn = n_done;
    run_job(2, 0, 1'b1, 100, da, ea, ma, bc);
    checks++;
    if (da !== 16 || n_ld - b_ld !== 2) begin
      failures++; $display("FAIL held_start got=done%0d/ld%0d exp=done16/ld2", da, n_ld - b_ld);
    end
    checks++;
    if (n_done - b_dn !== 1) begin failures++; $display("FAIL held_single_done got=%0d exp=1", n_done - b_dn); end
  endtask

  initial begin
    test_reset();
    test_zero_tiles();
    test_three_tiles();
    test_back_to_back();
    test_max_tiles();
    test_timeout();
    test_watchdog_off();
    test_same_cycle_done();
    test_done_wins();
    test_abort_reset();
    test_busy_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
